axi_stream_strip_header: RTL and testbench

- Strips a per-packet header of byte_strip_cnt bytes (0..DATA_BYTE_WD) from the front of an AXI-Stream packet.
- Presents the stripped header on a side channel.
- Re-aligns the remaining payload so that every non-last output beat is full and keep stays MSB-aligned.
- Sits on the receive side as the inverse of axi_stream_insert_header, using the same byte order (data[DATA_WD-1 -: 8] is the first byte).

---
 rtl/axi_stream_hdr_pkg.sv | 35 +++
 rtl/axi_stream_byte_merge.sv | 41 ++++
 rtl/axi_stream_strip_header.sv | 201 ++++++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_hdr_pkg.sv
// Shared types and byte-count helpers for the header insert/strip stream blocks.
package axi_stream_hdr_pkg;

  localparam int DATA_WD_DEF = 32;
  localparam int MAX_BYTES   = 64;

  typedef logic [MAX_BYTES-1:0] keep_max_t;

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

  function automatic int unsigned keep_to_cnt(input keep_max_t keep);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) cnt++;
    end
    return cnt;
  endfunction

  function automatic keep_max_t cnt_to_keep_lsb(input int unsigned cnt);
    keep_max_t k;
    k = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) k[i] = (i < cnt);
    return k;
  endfunction

  // MSB-aligned within the low nbytes bits; callers cast down to their own width.
  function automatic keep_max_t cnt_to_keep_msb(input int unsigned cnt, input int unsigned nbytes);
    keep_max_t k;
    k = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) k[i] = (i < nbytes) && (i + cnt >= nbytes);
    return k;
  endfunction

endpackage

// File: rtl/axi_stream_byte_merge.sv
// Appends the top bytes of a beat behind an R-byte MSB-aligned residual and
// returns the merged word plus the bytes that did not fit.
module axi_stream_byte_merge
  import axi_stream_hdr_pkg::*;
#(
  parameter int DATA_WD      = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]     resid,
  input  logic [BYTE_CNT_WD-1:0] resid_cnt,
  input  logic [DATA_WD-1:0]     beat,
  input  logic [BYTE_CNT_WD-1:0] beat_cnt,
  output logic [DATA_WD-1:0]     merged,
  output logic [DATA_WD-1:0]     leftover,
  output logic [BYTE_CNT_WD-1:0] leftover_cnt
);

  localparam logic [BYTE_CNT_WD:0] W_CNT = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);

  logic [DATA_WD-1:0]   resid_m;
  logic [DATA_WD-1:0]   beat_m;
  logic [2*DATA_WD-1:0] cat;
  logic [BYTE_CNT_WD:0] total;

  always_comb begin
    resid_m = '0;
    beat_m  = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      if (i < int'(resid_cnt)) resid_m[DATA_WD-1-8*i -: 8] = resid[DATA_WD-1-8*i -: 8];
      if (i < int'(beat_cnt))  beat_m[DATA_WD-1-8*i -: 8]  = beat[DATA_WD-1-8*i -: 8];
    end
    cat = {resid_m, {DATA_WD{1'b0}}} |
          ({{DATA_WD{1'b0}}, beat_m} << (8 * (DATA_BYTE_WD - int'(resid_cnt))));
    merged   = cat[2*DATA_WD-1 -: DATA_WD];
    leftover = cat[DATA_WD-1:0];
    total    = {1'b0, resid_cnt} + {1'b0, beat_cnt};
    leftover_cnt = (total > W_CNT) ? BYTE_CNT_WD'(total - W_CNT) : '0;
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Removes an N-byte header from each AXI-Stream packet, emits it on a side
// channel and re-packs the payload into full MSB-aligned beats.
//   state  | meaning
//   IDLE   | waiting for a strip command
//   FIRST  | waiting for the first beat; header taken from it
//   STREAM | merging residual with each following beat
//   FLUSH  | emitting the final residual after the last input beat
module axi_stream_strip_header
  import axi_stream_hdr_pkg::*;
#(
  parameter int DATA_WD      = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,
  output logic                    err_short
);

  localparam logic [BYTE_CNT_WD-1:0] W_CNT_S = BYTE_CNT_WD'(DATA_BYTE_WD);
  localparam logic [BYTE_CNT_WD:0]   W_CNT   = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);

  state_t state, state_nxt;
  logic [BYTE_CNT_WD-1:0]  n_reg, n_nxt;
  logic [DATA_WD-1:0]      resid, resid_nxt;
  logic [BYTE_CNT_WD-1:0]  resid_cnt, resid_cnt_nxt;
  logic                    valid_out_nxt, last_out_nxt;
  logic [DATA_WD-1:0]      data_out_nxt;
  logic [DATA_BYTE_WD-1:0] keep_out_nxt;
  logic                    valid_hdr_nxt;
  logic [DATA_WD-1:0]      data_hdr_nxt;
  logic [DATA_BYTE_WD-1:0] keep_hdr_nxt;
  logic                    err_nxt;

  logic                    out_free, hdr_free, accept;
  logic [BYTE_CNT_WD-1:0]  beat_cnt, hdr_bytes, first_rem;
  logic [DATA_WD-1:0]      beat_m, first_resid, hdr_word;
  logic [BYTE_CNT_WD:0]    total;
  logic [DATA_WD-1:0]      merged, leftover;
  logic [BYTE_CNT_WD-1:0]  leftover_cnt;

  axi_stream_byte_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_merge (
    .resid        (resid),
    .resid_cnt    (resid_cnt),
    .beat         (data_in),
    .beat_cnt     (beat_cnt),
    .merged       (merged),
    .leftover     (leftover),
    .leftover_cnt (leftover_cnt)
  );

  assign out_free    = !valid_out || ready_out;
  assign hdr_free    = !valid_hdr || ready_hdr;
  assign ready_in    = ((state == FIRST) && out_free && hdr_free) || ((state == STREAM) && out_free);
  assign ready_strip = (state == IDLE);
  assign accept      = valid_in && ready_in;

  always_comb begin
    beat_cnt = BYTE_CNT_WD'(keep_to_cnt(keep_max_t'(keep_in)));
    for (int i = 0; i < DATA_BYTE_WD; i++) beat_m[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
    hdr_bytes   = (beat_cnt < n_reg) ? beat_cnt : n_reg;
    hdr_word    = beat_m >> (8 * (DATA_BYTE_WD - int'(hdr_bytes)));
    first_resid = beat_m << (8 * int'(n_reg));
    first_rem   = (beat_cnt > n_reg) ? beat_cnt - n_reg : '0;
    total       = {1'b0, resid_cnt} + {1'b0, beat_cnt};
  end

  always_comb begin
    state_nxt     = state;
    n_nxt         = n_reg;
    resid_nxt     = resid;
    resid_cnt_nxt = resid_cnt;
    valid_out_nxt = valid_out && !ready_out;
    data_out_nxt  = data_out;
    keep_out_nxt  = keep_out;
    last_out_nxt  = last_out;
    valid_hdr_nxt = valid_hdr && !ready_hdr;
    data_hdr_nxt  = data_hdr;
    keep_hdr_nxt  = keep_hdr;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (valid_strip) begin
          n_nxt     = (byte_strip_cnt > W_CNT_S) ? W_CNT_S : byte_strip_cnt;
          state_nxt = FIRST;
        end
      end
      FIRST: begin
        if (accept) begin
          if (n_reg != '0) begin
            valid_hdr_nxt = 1'b1;
            data_hdr_nxt  = hdr_word;
            keep_hdr_nxt  = DATA_BYTE_WD'(cnt_to_keep_lsb(32'(hdr_bytes)));
          end
          resid_nxt     = first_resid;
          resid_cnt_nxt = first_rem;
          if (!last_in) begin
            state_nxt = STREAM;
          end else begin
            state_nxt     = IDLE;
            resid_cnt_nxt = '0;
            if (first_rem != '0) begin
              valid_out_nxt = 1'b1;
              data_out_nxt  = first_resid;
              keep_out_nxt  = DATA_BYTE_WD'(cnt_to_keep_msb(32'(first_rem), DATA_BYTE_WD));
              last_out_nxt  = 1'b1;
            end
            if (beat_cnt < n_reg) err_nxt = 1'b1;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          if (last_in && (total <= W_CNT)) begin
            valid_out_nxt = 1'b1;
            data_out_nxt  = merged;
            keep_out_nxt  = DATA_BYTE_WD'(cnt_to_keep_msb(32'(total), DATA_BYTE_WD));
            last_out_nxt  = 1'b1;
            resid_cnt_nxt = '0;
            state_nxt     = IDLE;
          end else if (total >= W_CNT) begin
            valid_out_nxt = 1'b1;
            data_out_nxt  = merged;
            keep_out_nxt  = '1;
            last_out_nxt  = 1'b0;
            resid_nxt     = leftover;
            resid_cnt_nxt = leftover_cnt;
            if (last_in) state_nxt = FLUSH;
          end else begin
            // short non-last beat: keep accumulating until a full word exists
            resid_nxt     = merged;
            resid_cnt_nxt = BYTE_CNT_WD'(total);
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          valid_out_nxt = 1'b1;
          data_out_nxt  = resid;
          keep_out_nxt  = DATA_BYTE_WD'(cnt_to_keep_msb(32'(resid_cnt), DATA_BYTE_WD));
          last_out_nxt  = 1'b1;
          resid_cnt_nxt = '0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_reg     <= '0;
      resid     <= '0;
      resid_cnt <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
      valid_hdr <= 1'b0;
      data_hdr  <= '0;
      keep_hdr  <= '0;
      err_short <= 1'b0;
    end else begin
      state     <= state_nxt;
      n_reg     <= n_nxt;
      resid     <= resid_nxt;
      resid_cnt <= resid_cnt_nxt;
      valid_out <= valid_out_nxt;
      data_out  <= data_out_nxt;
      keep_out  <= keep_out_nxt;
      last_out  <= last_out_nxt;
      valid_hdr <= valid_hdr_nxt;
      data_hdr  <= data_hdr_nxt;
      keep_hdr  <= keep_hdr_nxt;
      err_short <= err_nxt;
    end
  end

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: a byte-level reference model
// predicts header and payload beats that a negedge monitor then compares.
module tb_axi_stream_strip_header;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_strip;
  logic [2:0]  byte_strip_cnt;
  logic        ready_strip;
  logic        valid_hdr;
  logic [31:0] data_hdr;
  logic [3:0]  keep_hdr;
  logic        ready_hdr;
  logic        err_short;

  axi_stream_strip_header dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .valid_strip    (valid_strip),
    .byte_strip_cnt (byte_strip_cnt),
    .ready_strip    (ready_strip),
    .valid_hdr      (valid_hdr),
    .data_hdr       (data_hdr),
    .keep_hdr       (keep_hdr),
    .ready_hdr      (ready_hdr),
    .err_short      (err_short)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t pkt[$];
  beat_t exp_out_q[$];
  beat_t exp_hdr_q[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_err = 0;
  int    err_cycles = 0;
  bit    stress = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic add_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    pkt.push_back(b);
  endtask

  // Reference: flatten the packet to a byte list, peel off the header, re-chunk the rest.
  task automatic model_pkt(input int n);
    logic [7:0]  bq[$];
    logic [31:0] d;
    logic [3:0]  k;
    beat_t       h;
    beat_t       o;
    int nn, v0, hb, idx;
    nn = (n > 4) ? 4 : n;
    v0 = 0;
    k  = pkt[0].keep;
    for (int i = 0; i < 4; i++) if (k[i]) v0++;
    foreach (pkt[b]) begin
      d = pkt[b].data;
      k = pkt[b].keep;
      for (int i = 0; i < 4; i++) if (k[3-i]) bq.push_back(d[31-8*i -: 8]);
    end
    hb = (v0 < nn) ? v0 : nn;
    if (nn > 0) begin
      h = '0;
      for (int i = 0; i < hb; i++) h.data = (h.data << 8) | {24'h0, bq[i]};
      h.keep = 4'((1 << hb) - 1);
      exp_hdr_q.push_back(h);
    end
    if (pkt.size() == 1 && v0 < nn) exp_err++;
    idx = hb;
    while (idx < bq.size()) begin
      o = '0;
      for (int j = 0; j < 4; j++) begin
        if (idx < bq.size()) begin
          o.data[31-8*j -: 8] = bq[idx];
          o.keep[3-j] = 1'b1;
          idx++;
        end
      end
      o.last = (idx >= bq.size());
      exp_out_q.push_back(o);
    end
  endtask

  task automatic send_pkt(input int n);
    int cyc;
    bit got;
    model_pkt(n);
    valid_strip    = 1'b1;
    byte_strip_cnt = 3'(n);
    cyc = 0;
    got = 0;
    while (!got && cyc < 200) begin
      @(negedge clk); got = ready_strip;
      @(posedge clk); #1; cyc++;
    end
    check_val("strip_hs", 32'(got), 1);
    valid_strip = 1'b0;
    foreach (pkt[b]) begin
      valid_in = 1'b1;
      data_in  = pkt[b].data;
      keep_in  = pkt[b].keep;
      last_in  = pkt[b].last;
      cyc = 0;
      got = 0;
      while (!got && cyc < 200) begin
        @(negedge clk); got = ready_in;
        @(posedge clk); #1; cyc++;
      end
      check_val("in_hs", 32'(got), 1);
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while ((exp_out_q.size() != 0 || exp_hdr_q.size() != 0) && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_out_left"}, 32'(exp_out_q.size()), 0);
    check_val({tag, "_hdr_left"}, 32'(exp_hdr_q.size()), 0);
    check_val({tag, "_err_cycles"}, 32'(err_cycles), 32'(exp_err));
    exp_out_q.delete();
    exp_hdr_q.delete();
  endtask

  logic [31:0] held_out, held_hdr;
  bit          held_out_v = 0, held_hdr_v = 0;

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      held_out_v <= 0;
      held_hdr_v <= 0;
    end else begin
      if (err_short) err_cycles++;
      if (held_out_v && valid_out) check_val("out_stable", data_out, held_out);
      if (held_hdr_v && valid_hdr) check_val("hdr_stable", data_hdr, held_hdr);
      held_out_v <= valid_out && !ready_out;
      held_out   <= data_out;
      held_hdr_v <= valid_hdr && !ready_hdr;
      held_hdr   <= data_hdr;
      if (valid_out && ready_out) begin
        if (exp_out_q.size() == 0) begin
          check_val("out_extra", 32'(exp_out_q.size()), 1);
        end else begin
          e = exp_out_q.pop_front();
          check_val("out_data", data_out, e.data);
          check_val("out_keep", 32'(keep_out), 32'(e.keep));
          check_val("out_last", 32'(last_out), 32'(e.last));
        end
      end
      if (valid_hdr && ready_hdr) begin
        if (exp_hdr_q.size() == 0) begin
          check_val("hdr_extra", 32'(exp_hdr_q.size()), 1);
        end else begin
          e = exp_hdr_q.pop_front();
          check_val("hdr_data", data_hdr, e.data);
          check_val("hdr_keep", 32'(keep_hdr), 32'(e.keep));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    ready_out = stress ? ($urandom_range(0, 4) != 0) : 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit got;
    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_strip = 1'b0; byte_strip_cnt = '0;
    ready_out = 1'b1; ready_hdr = 1'b1;
    #1;
    check_val("rst_valid_out", 32'(valid_out), 0);
    check_val("rst_valid_hdr", 32'(valid_hdr), 0);
    check_val("rst_last_out", 32'(last_out), 0);
    check_val("rst_err", 32'(err_short), 0);
    check_val("rst_data_out", data_out, 0);
    check_val("rst_keep_out", 32'(keep_out), 0);
    check_val("rst_data_hdr", data_hdr, 0);
    check_val("rst_ready_strip", 32'(ready_strip), 1);
    check_val("rst_ready_in", 32'(ready_in), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    pkt.delete(); add_beat(32'hA1A2A3A4, 4'b1111, 0); add_beat(32'hB1B2B3B4, 4'b1100, 1);
    send_pkt(2); drain("s1");

    pkt.delete(); add_beat(32'h11223344, 4'b1111, 0); add_beat(32'h55667788, 4'b1110, 1);
    send_pkt(1); drain("s2");

    pkt.delete(); add_beat(32'hDEADBEEF, 4'b1111, 0); add_beat(32'hCAFEF00D, 4'b1000, 1);
    send_pkt(0); drain("s3");

    pkt.delete(); add_beat(32'h01020304, 4'b1111, 1);
    send_pkt(4);
    check_val("s4_ready_strip", 32'(ready_strip), 1);
    drain("s4");

    pkt.delete(); add_beat(32'h0A0B0000, 4'b1100, 1);
    send_pkt(3);
    check_val("s5_ready_strip", 32'(ready_strip), 1);
    drain("s5");

    pkt.delete(); add_beat(32'h11223344, 4'b1111, 0); add_beat(32'h55667788, 4'b1100, 1);
    send_pkt(7); drain("clamp");

    stress = 1;
    for (int r = 0; r < 3; r++) begin
      pkt.delete(); add_beat(32'h11223344, 4'b1111, 0); add_beat(32'h55667788, 4'b1110, 1);
      ready_hdr = 1'b0;
      fork
        send_pkt(1);
        begin
          int c2;
          c2 = 0;
          while (!valid_hdr && c2 < 200) begin @(negedge clk); c2++; end
          repeat (3) @(posedge clk);
          #1 ready_hdr = 1'b1;
        end
      join
      drain("stress");
    end
    stress = 0;

    ready_hdr = 1'b0;
    valid_strip = 1'b1; byte_strip_cnt = 3'd1;
    cyc = 0; got = 0;
    while (!got && cyc < 200) begin @(negedge clk); got = ready_strip; @(posedge clk); #1; cyc++; end
    valid_strip = 1'b0;
    valid_in = 1'b1; data_in = 32'h11223344; keep_in = 4'b1111; last_in = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 200) begin @(negedge clk); got = ready_in; @(posedge clk); #1; cyc++; end
    valid_in = 1'b0;
    @(negedge clk);
    check_val("rst_mid_hdr_before", 32'(valid_hdr), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_valid_out", 32'(valid_out), 0);
    check_val("rst_mid_valid_hdr", 32'(valid_hdr), 0);
    check_val("rst_mid_ready_strip", 32'(ready_strip), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    ready_hdr = 1'b1;
    @(posedge clk); #1;
    pkt.delete(); add_beat(32'hA1A2A3A4, 4'b1111, 0); add_beat(32'hB1B2B3B4, 4'b1100, 1);
    send_pkt(2); drain("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
